// File: rtl/regfile_param_if.sv
// Register-file bus: two registered read ports, one combinational debug port,
// one write port, clear request and status.
interface regfile_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DBG_W  = 7
);
   logic [ADDR_W-1:0] rnum_a;
   logic              re_a;
   logic [DATA_W-1:0] rdata_a;
   logic [ADDR_W-1:0] rnum_b;
   logic              re_b;
   logic [DATA_W-1:0] rdata_b;
   logic [ADDR_W-1:0] rnum_c;
   logic [DATA_W-1:0] rdata_c;
   logic [ADDR_W-1:0] wnum;
   logic [DATA_W-1:0] wdata;
   logic              we;
   logic              clr_req;
   logic              busy;
   logic [DBG_W-1:0]  dbg_out;

   modport master (
      output rnum_a, re_a, rnum_b, re_b, rnum_c, wnum, wdata, we, clr_req,
      input  rdata_a, rdata_b, rdata_c, busy, dbg_out
   );

   modport slave (
      input  rnum_a, re_a, rnum_b, re_b, rnum_c, wnum, wdata, we, clr_req,
      output rdata_a, rdata_b, rdata_c, busy, dbg_out
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: r0 hardwired to zero, two registered read ports
// with optional write bypass, combinational debug read and a sequenced clear.
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 5,
   parameter int BYPASS   = 1,
   parameter int DBG_REG  = 6,
   parameter int DBG_W    = 7
) (
   input logic             clk,
   input logic             rst,
   regfile_param_if.slave  bus
);
   typedef enum logic {IDLE, CLEAR} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   // r0 has no storage at all, so it can never hold a nonzero value
   logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
   logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];
   logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
   logic [DATA_W-1:0] rd_a, rd_b, rd_c;
   logic              wr_ok;

   assign wr_ok = bus.we && (state_q == IDLE) && (bus.wnum != '0) &&
                  (int'(bus.wnum) < NUM_REGS);

   // Out-of-range and zero register numbers fall through to the zero default
   always_comb begin
      rd_a = '0;
      rd_b = '0;
      rd_c = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (bus.rnum_a == ADDR_W'(i)) rd_a = regs_q[i];
         if (bus.rnum_b == ADDR_W'(i)) rd_b = regs_q[i];
         if (bus.rnum_c == ADDR_W'(i)) rd_c = regs_q[i];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      regs_d    = regs_q;
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;
      unique case (state_q)
         IDLE: begin
            if (bus.clr_req) begin
               state_d = CLEAR;
               cnt_d   = ADDR_W'(1);
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(NUM_REGS-1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
      endcase
      // A write accepted with clr_req lands first and is then cleared in turn
      for (int i = 1; i < NUM_REGS; i++) begin
         if (wr_ok && bus.wnum == ADDR_W'(i))             regs_d[i] = bus.wdata;
         if (state_q == CLEAR && cnt_q == ADDR_W'(i))     regs_d[i] = '0;
      end
      if (bus.re_a)
         rdata_a_d = (BYPASS != 0 && wr_ok && bus.wnum == bus.rnum_a) ? bus.wdata : rd_a;
      if (bus.re_b)
         rdata_b_d = (BYPASS != 0 && wr_ok && bus.wnum == bus.rnum_b) ? bus.wdata : rd_b;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
         for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
         for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      end
   end

   assign bus.rdata_a = rdata_a_q;
   assign bus.rdata_b = rdata_b_q;
   assign bus.rdata_c = rd_c;
   assign bus.busy    = (state_q == CLEAR);

   generate
      if (DBG_REG >= 1 && DBG_REG < NUM_REGS) begin : g_dbg
         assign bus.dbg_out = regs_q[DBG_REG][DBG_W-1:0];
      end else begin : g_dbg_zero
         assign bus.dbg_out = '0;
      end
   endgenerate
endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: vector table for basic read/write/bypass,
// hand-written sequences for the clear engine and reset during a clear.
module tb_regfile_param;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   regfile_param_if #(.DATA_W(32), .ADDR_W(5), .DBG_W(7)) bus ();
   regfile_param_if #(.DATA_W(32), .ADDR_W(5), .DBG_W(7)) bus_nb ();

   // Second instance without bypass sees identical stimulus
   assign bus_nb.rnum_a  = bus.rnum_a;
   assign bus_nb.re_a    = bus.re_a;
   assign bus_nb.rnum_b  = bus.rnum_b;
   assign bus_nb.re_b    = bus.re_b;
   assign bus_nb.rnum_c  = bus.rnum_c;
   assign bus_nb.wnum    = bus.wnum;
   assign bus_nb.wdata   = bus.wdata;
   assign bus_nb.we      = bus.we;
   assign bus_nb.clr_req = bus.clr_req;

   regfile_param #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(5), .BYPASS(1),
                   .DBG_REG(6), .DBG_W(7)) u_dut (.clk(clk), .rst(rst), .bus(bus));
   regfile_param #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(5), .BYPASS(0),
                   .DBG_REG(6), .DBG_W(7)) u_nb  (.clk(clk), .rst(rst), .bus(bus_nb));

   typedef struct {
      logic        we;
      logic [4:0]  wnum;
      logic [31:0] wdata;
      logic        re_a;
      logic [4:0]  rnum_a;
      logic        re_b;
      logic [4:0]  rnum_b;
      logic [4:0]  rnum_c;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [31:0] ec;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic [4:0] wn, input logic [31:0] wd,
                      input logic ra, input logic [4:0] na, input logic rb,
                      input logic [4:0] nb, input logic [4:0] nc,
                      input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec);
      vec_t v;
      v.we = we; v.wnum = wn; v.wdata = wd; v.re_a = ra; v.rnum_a = na;
      v.re_b = rb; v.rnum_b = nb; v.rnum_c = nc; v.ea = ea; v.eb = eb; v.ec = ec;
      vecs.push_back(v);
   endtask

   task automatic idle_inputs();
      bus.we = 1'b0; bus.wnum = '0; bus.wdata = '0; bus.re_a = 1'b0; bus.rnum_a = '0;
      bus.re_b = 1'b0; bus.rnum_b = '0; bus.rnum_c = '0; bus.clr_req = 1'b0;
   endtask

   task automatic write_reg(input logic [4:0] n, input logic [31:0] d);
      @(negedge clk);
      idle_inputs();
      bus.we = 1'b1; bus.wnum = n; bus.wdata = d;
      @(posedge clk); #1;
   endtask

   initial begin
      int busy_cnt;
      idle_inputs();
      #2 rst = 1'b0;
      #1;
      chk("reset_rdata_a", bus.rdata_a, 32'h0);
      chk("reset_rdata_b", bus.rdata_b, 32'h0);
      chk("reset_busy", {31'b0, bus.busy}, 32'h0);
      chk("reset_dbg", {25'b0, bus.dbg_out}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      //   we    wnum    wdata          re_a  rnum_a re_b  rnum_b rnum_c  ea             eb             ec
      add(1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd0,  5'd3,  32'h0,         32'h0,         32'hDEADBEEF);
      add(1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd0,  5'd3,  32'hDEADBEEF,  32'h0,         32'hDEADBEEF);
      add(1'b1, 5'd0,  32'h1234,     1'b1, 5'd0,  1'b1, 5'd3,  5'd0,  32'h0,         32'hDEADBEEF,  32'h0);
      add(1'b1, 5'd20, 32'h55,       1'b1, 5'd20, 1'b1, 5'd0,  5'd20, 32'h0,         32'h0,         32'h0);
      add(1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b1, 5'd4,  5'd4,  32'hDEADBEEF,  32'h0,         32'h0);
      add(1'b1, 5'd7,  32'h7,        1'b0, 5'd0,  1'b0, 5'd0,  5'd7,  32'hDEADBEEF,  32'h0,         32'h7);
      add(1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd0,  5'd3,  32'h7,         32'h0,         32'hDEADBEEF);
      add(1'b1, 5'd7,  32'h99,       1'b0, 5'd7,  1'b0, 5'd0,  5'd7,  32'h7,         32'h0,         32'h99);
      add(1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  1'b0, 5'd0,  5'd7,  32'h7,         32'h0,         32'h99);
      add(1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd0,  5'd7,  32'h99,        32'h0,         32'h99);
      add(1'b1, 5'd15, 32'hCAFE,     1'b0, 5'd0,  1'b1, 5'd15, 5'd15, 32'h99,        32'hCAFE,      32'hCAFE);
      add(1'b1, 5'd5,  32'h11,       1'b0, 5'd0,  1'b1, 5'd5,  5'd5,  32'h99,        32'h11,        32'h11);
      add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd15, 5'd0,  32'h99,        32'hCAFE,      32'h0);

      foreach (vecs[i]) begin
         @(negedge clk);
         bus.we = vecs[i].we; bus.wnum = vecs[i].wnum; bus.wdata = vecs[i].wdata;
         bus.re_a = vecs[i].re_a; bus.rnum_a = vecs[i].rnum_a;
         bus.re_b = vecs[i].re_b; bus.rnum_b = vecs[i].rnum_b;
         bus.rnum_c = vecs[i].rnum_c; bus.clr_req = 1'b0;
         @(posedge clk); #1;
         chk($sformatf("vec%0d_rdata_a", i), bus.rdata_a, vecs[i].ea);
         chk($sformatf("vec%0d_rdata_b", i), bus.rdata_b, vecs[i].eb);
         chk($sformatf("vec%0d_rdata_c", i), bus.rdata_c, vecs[i].ec);
      end

      // Same-edge write and read of r5 (previously 0x11) on both builds
      @(negedge clk);
      idle_inputs();
      bus.we = 1'b1; bus.wnum = 5'd5; bus.wdata = 32'hA5A5A5A5;
      bus.re_a = 1'b1; bus.rnum_a = 5'd5; bus.re_b = 1'b1; bus.rnum_b = 5'd5; bus.rnum_c = 5'd5;
      @(posedge clk); #1;
      chk("byp_a", bus.rdata_a, 32'hA5A5A5A5);
      chk("byp_b", bus.rdata_b, 32'hA5A5A5A5);
      chk("nobyp_a", bus_nb.rdata_a, 32'h11);
      chk("nobyp_b", bus_nb.rdata_b, 32'h11);
      chk("nobyp_c", bus_nb.rdata_c, 32'hA5A5A5A5);
      @(negedge clk);
      idle_inputs();
      bus.re_a = 1'b1; bus.rnum_a = 5'd5;
      @(posedge clk); #1;
      chk("byp_r5_after", bus.rdata_a, 32'hA5A5A5A5);
      chk("nobyp_r5_after", bus_nb.rdata_a, 32'hA5A5A5A5);

      // Clear sequence
      for (int i = 1; i < 16; i++) write_reg(5'(i), 32'(i));
      chk("dbg_before_clear", {25'b0, bus.dbg_out}, 32'h6);
      @(negedge clk);
      idle_inputs();
      bus.clr_req = 1'b1; bus.we = 1'b1; bus.wnum = 5'd1; bus.wdata = 32'h77; bus.rnum_c = 5'd1;
      @(posedge clk); #1;
      chk("clr_start_busy", {31'b0, bus.busy}, 32'h1);
      chk("clr_with_write_r1", bus.rdata_c, 32'h77);
      busy_cnt = 0;
      for (int k = 1; k <= 40 && bus.busy; k++) begin
         busy_cnt++;
         @(negedge clk);
         idle_inputs();
         bus.we = (k == 1); bus.wnum = 5'd2; bus.wdata = 32'hFF;
         bus.clr_req = (k == 3);
         bus.rnum_c = (k == 1) ? 5'd2 : (k == 3) ? 5'd10 : 5'd1;
         @(posedge clk); #1;
         if (k == 1) chk("clr_write_dropped_r2", bus.rdata_c, 32'h2);
         if (k == 3) chk("clr_uncleared_r10", bus.rdata_c, 32'hA);
         if (k == 3) chk("clr_cleared_r1", u_dut.regs_q[1], 32'h0);
         if (k == 5) chk("clr_dbg_before_r6", {25'b0, bus.dbg_out}, 32'h6);
         if (k == 6) chk("clr_dbg_after_r6", {25'b0, bus.dbg_out}, 32'h0);
      end
      chk("clr_busy_cycles", 32'(busy_cnt), 32'd15);
      @(negedge clk);
      @(negedge clk);
      chk("clr_no_restart", {31'b0, bus.busy}, 32'h0);
      for (int i = 0; i < 16; i++) begin
         bus.rnum_c = 5'(i);
         #1;
         chk($sformatf("clr_zero_r%0d", i), bus.rdata_c, 32'h0);
      end
      @(negedge clk);
      idle_inputs();
      bus.re_a = 1'b1; bus.rnum_a = 5'd15;
      @(posedge clk); #1;
      chk("clr_zero_port_a_r15", bus.rdata_a, 32'h0);

      // Reset in the middle of a clear
      write_reg(5'd6, 32'h3F);
      write_reg(5'd9, 32'h9);
      @(negedge clk);
      idle_inputs();
      bus.re_a = 1'b1; bus.rnum_a = 5'd9; bus.re_b = 1'b1; bus.rnum_b = 5'd6;
      @(posedge clk); #1;
      chk("pre_rst_a", bus.rdata_a, 32'h9);
      @(negedge clk);
      idle_inputs();
      bus.clr_req = 1'b1; bus.rnum_c = 5'd9;
      @(posedge clk);
      @(negedge clk);
      bus.clr_req = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("midclr_busy", {31'b0, bus.busy}, 32'h1);
      chk("midclr_r9", bus.rdata_c, 32'h9);
      chk("midclr_dbg", {25'b0, bus.dbg_out}, 32'h3F);
      rst = 1'b0;
      #1;
      chk("async_rst_busy", {31'b0, bus.busy}, 32'h0);
      chk("async_rst_a", bus.rdata_a, 32'h0);
      chk("async_rst_b", bus.rdata_b, 32'h0);
      chk("async_rst_c", bus.rdata_c, 32'h0);
      chk("async_rst_dbg", {25'b0, bus.dbg_out}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_idle", {31'b0, bus.busy}, 32'h0);
      write_reg(5'd9, 32'h123);
      @(negedge clk);
      idle_inputs();
      bus.re_a = 1'b1; bus.rnum_a = 5'd9;
      @(posedge clk); #1;
      chk("post_rst_read", bus.rdata_a, 32'h123);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
